// File: rtl/mem_cmd_splitter.sv
// mem_cmd_splitter: splits a (address, length, tag) memory command into chunks
// that never cross a CHUNK_BYTES-aligned boundary and are at most CHUNK_BYTES long.
// Latency: first chunk valid 1 cycle after acceptance; chunks back-to-back on out_ready.
// Backpressure: out_* registered and held while out_valid && !out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n                         single clock, synchronous active-low reset
//   in_valid/in_ready/in_address/in_length/in_tag         command slave channel
//   out_valid/out_ready/out_address/out_length/out_tag/out_last  chunk master channel
//   busy (state==SPLIT), cmd_done (1-cycle pulse after last chunk),
//   zero_len_err (1-cycle pulse after a zero-length command is accepted)
module mem_cmd_splitter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH   = 32,
  parameter int CHUNK_BYTES = 4096,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_address,
  input  logic [LEN_WIDTH-1:0]  in_length,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_address,
  output logic [LEN_WIDTH-1:0]  out_length,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_last,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  zero_len_err
);

  localparam int CB_LOG = $clog2(CHUNK_BYTES);
  localparam int LW1    = LEN_WIDTH + 1;

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                state, state_nxt;
  // Bytes still owed for the command, including the chunk currently on out_*.
  logic [LEN_WIDTH-1:0]  rem;

  logic                  in_fire, out_fire;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [LEN_WIDTH-1:0]  src_rem;
  logic [LW1-1:0]        offset, room, clen_w;
  logic [LEN_WIDTH-1:0]  clen;
  logic                  clast;

  assign in_ready = (state == IDLE);
  assign busy     = (state == SPLIT);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // The chunk calculator is shared: in IDLE it sizes the first chunk of the
  // incoming command, in SPLIT it sizes the chunk following the current one.
  // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
  assign src_addr = (state == IDLE) ? in_address : out_address + ADDR_WIDTH'(out_length);
  assign src_rem  = (state == IDLE) ? in_length  : rem - out_length;

  // One extra bit so that CHUNK_BYTES itself is representable.
  assign offset = LW1'(src_addr[CB_LOG-1:0]);
  assign room   = LW1'(CHUNK_BYTES) - offset;
  assign clen_w = ({1'b0, src_rem} < room) ? {1'b0, src_rem} : room;
  assign clen   = clen_w[LEN_WIDTH-1:0];
  assign clast  = (clen_w == {1'b0, src_rem});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire && in_length != '0) state_nxt = SPLIT;
      SPLIT:   if (out_fire && out_last)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_address  <= '0;
      out_length   <= '0;
      out_tag      <= '0;
      out_last     <= 1'b0;
      rem          <= '0;
      cmd_done     <= 1'b0;
      zero_len_err <= 1'b0;
    end else begin
      cmd_done     <= 1'b0;
      zero_len_err <= 1'b0;
      if (state == IDLE) begin
        if (in_fire) begin
          if (in_length == '0) begin
            zero_len_err <= 1'b1;
          end else begin
            out_valid   <= 1'b1;
            out_address <= src_addr;
            out_length  <= clen;
            out_last    <= clast;
            out_tag     <= in_tag;
            rem         <= src_rem;
          end
        end
      end else if (out_fire) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          cmd_done  <= 1'b1;
        end else begin
          out_address <= src_addr;
          out_length  <= clen;
          out_last    <= clast;
          rem         <= src_rem;
        end
      end
    end
  end

endmodule

// File: doc/mem_cmd_splitter.md
MEM_CMD_SPLITTER -- requirements
Module: mem_cmd_splitter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning byte-address width of commands.
REQ-002 SHALL have parameter LEN_WIDTH, default 32, meaning byte-length width of commands.
REQ-003 SHALL have parameter CHUNK_BYTES, default 4096, meaning maximum chunk size and alignment boundary; power of two, at least 64.
REQ-004 SHALL have parameter TAG_WIDTH, default 8, meaning tag width; carries values such as 8'h0a/8'h0b for A/B reads.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning synchronous, active-low reset.
REQ-007 SHALL have ports in_valid input 1, in_ready output 1, in_address input ADDR_WIDTH, in_length input LEN_WIDTH and in_tag input TAG_WIDTH, meaning the command slave channel.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1, out_address output ADDR_WIDTH, out_length output LEN_WIDTH, out_tag output TAG_WIDTH and out_last output 1, meaning the chunk master channel.
REQ-009 SHALL have ports busy output 1, cmd_done output 1 and zero_len_err output 1, meaning the status outputs.

Function
REQ-010 SHALL implement FSM states IDLE and SPLIT.
REQ-011 SHALL assert in_ready only in IDLE, combinationally equal to (state==IDLE).
REQ-012 SHALL, on an IDLE handshake with in_length>0, latch address, remaining length and tag, then enter SPLIT.
REQ-013 SHALL, on an IDLE handshake with in_length==0, stay in IDLE, emit no chunk, and pulse zero_len_err high for exactly the next cycle.
REQ-014 SHALL compute chunk length = min(remaining, CHUNK_BYTES - (address mod CHUNK_BYTES)), so no chunk crosses a CHUNK_BYTES-aligned boundary.
REQ-015 SHALL present the first chunk with out_valid=1 in the cycle after input acceptance (latency 1 cycle).
REQ-016 SHALL register all out_* signals and hold them stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, on each out handshake, advance address by chunk length (modulo 2^ADDR_WIDTH) and decrement remaining by chunk length; the next chunk is valid in the following cycle (back-to-back, no bubble).
REQ-018 SHALL set out_last=1 only on the chunk whose length equals the remaining length; out_tag SHALL equal the latched tag on every chunk.
REQ-019 SHALL, on the out_last handshake, return to IDLE, drop out_valid the next cycle, and pulse cmd_done for exactly that next cycle.
REQ-020 SHALL accept the next command no earlier than the cycle after the last-chunk handshake (one-cycle gap between commands).
REQ-021 SHALL drive busy=1 whenever state==SPLIT.
REQ-022 SHALL take CHUNK_BYTES=4096 as a full chunk, and SHALL let a chunk reach exactly the top of the address space, the next address wrapping to 0.
REQ-023 SHALL use LEN_WIDTH+1-bit internal chunk arithmetic so CHUNK_BYTES never overflows.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, go to IDLE and set out_valid=0, out_last=0, busy=0, cmd_done=0, zero_len_err=0, out_address=0, out_length=0 and out_tag=0.
REQ-025 SHALL, on reset mid-command, discard the in-flight command without emitting further chunks, with in_ready=1 in the first cycle after rst_n returns high.

Verification
REQ-026 SHALL verify, with CHUNK_BYTES=4096: in addr 0x1000 len 0x3000 tag 0x0a -> chunks (0x1000,0x1000),(0x2000,0x1000),(0x3000,0x1000), all tagged 0x0a, last only on the third, cmd_done one pulse.
REQ-027 SHALL verify: in addr 0x0F00 len 0x300 -> chunks (0x0F00,0x100),(0x1000,0x200), last on the second.
REQ-028 SHALL verify: in addr 0x10 len 0x20 tag 0x0b -> single chunk (0x10,0x20,last=1), first valid one cycle after acceptance.
REQ-029 SHALL verify: in len 0 -> no out_valid, zero_len_err high for one cycle, in_ready stays 1.
REQ-030 SHALL verify: out_ready held 0 for 5 cycles mid-command -> out_* unchanged across those cycles, no chunk lost or duplicated.
REQ-031 SHALL verify: rst_n low for 1 cycle during the second chunk of a 3-chunk command -> out_valid=0 and busy=0 next cycle, no further chunks, next command processed correctly.
